// File: rtl/note_highway_pkg.sv
// note_highway_pkg
// Shared definitions for the note highway: controller state encoding and
// chart word field helpers.
//   state_t  : IDLE, FETCH, RUN, DRAIN, DONE
//   end_bit(): bit index of the end-of-song marker in a chart word
package note_highway_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Chart word layout: [lanes] = end marker, [lanes-1:0] = note bits.
  function automatic int end_bit(input int lanes);
    return lanes;
  endfunction

endpackage

// File: rtl/note_highway_if.sv
// note_highway_if
// Bundles the note highway's control, chart ROM and display/processor
// signals.
//   start          song start request (level)
//   chart_addr     chart ROM address
//   chart_q        chart ROM word, valid one cycle after chart_addr
//   hit_clear      per-lane erase request for the hit window
//   gameclk        one-clock pulse per game tick
//   intersections  per-lane "note in hit window"
//   grid           full note grid, bit [r*LANES+l]
//   busy / done    controller status
// master = the highway, slave = whoever feeds and observes it.
interface note_highway_if #(
  parameter int LANES    = 4,
  parameter int ROWS     = 16,
  parameter int CHART_AW = 10
);
  logic                  start;
  logic [CHART_AW-1:0]   chart_addr;
  logic [LANES:0]        chart_q;
  logic [LANES-1:0]      hit_clear;
  logic                  gameclk;
  logic [LANES-1:0]      intersections;
  logic [LANES*ROWS-1:0] grid;
  logic                  busy;
  logic                  done;

  modport master (
    input  start, chart_q, hit_clear,
    output chart_addr, gameclk, intersections, grid, busy, done
  );

  modport slave (
    output start, chart_q, hit_clear,
    input  chart_addr, gameclk, intersections, grid, busy, done
  );
endinterface

// File: rtl/note_highway_tick_divider.sv
// tick_divider
// Free-running cycle counter 0..DIV-1 that wraps; tick is high during the
// terminal-count cycle while enabled.
//   clock  in   master clock
//   reset  in   synchronous active-high reset
//   en     in   count enable
//   clr    in   synchronous clear to 0
//   tick   out  terminal-count strobe (combinational)
module tick_divider #(
  parameter int DIV = 833333
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] count;

  assign tick = en && (count == CW'(DIV - 1));

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      count <= '0;
    end else if (en) begin
      count <= tick ? '0 : count + CW'(1);
    end
  end
endmodule

// File: rtl/note_highway.sv
// note_highway
// Scrolls a LANES-wide note chart down a ROWS-deep grid, one row per game
// tick, reading one chart word per tick from a synchronous ROM. Feeds the
// guitar processor (intersections, gameclk) and the display (grid).
//   clock  in   master clock
//   reset  in   synchronous active-high reset
//   bus    master modport of note_highway_if (start, chart ROM, hit_clear,
//          gameclk, intersections, grid, busy, done)
//
// state | meaning
// IDLE  | waiting for start
// FETCH | first chart word in flight from the ROM (two cycles)
// RUN   | scrolling chart rows in, one per tick
// DRAIN | end marker seen; scrolling empty rows until the grid clears
// DONE  | song finished, grid empty; start begins again at address 0
module note_highway
  import note_highway_pkg::*;
#(
  parameter int LANES    = 4,
  parameter int ROWS     = 16,
  parameter int HIT_ROWS = 2,
  parameter int TICK_DIV = 833333,
  parameter int CHART_AW = 10
) (
  input  logic           clock,
  input  logic           reset,
  note_highway_if.master bus
);
  localparam int END_BIT = end_bit(LANES);
  localparam int GW      = LANES * ROWS;
  localparam int WIN_LO  = ROWS - HIT_ROWS;

  state_t              state, state_next;
  logic                fetch_wait, fetch_wait_next;
  logic                fetch_pending, fetch_pending_next;
  logic [LANES:0]      prefetch, prefetch_next;
  logic [CHART_AW-1:0] addr, addr_next;
  logic [GW-1:0]       grid, grid_next;
  logic [GW-1:0]       clear_mask, cleared;
  logic [LANES-1:0]    win_or, inter;
  logic                gameclk, tick, scrolling;

  assign scrolling = (state == S_RUN) || (state == S_DRAIN);

  tick_divider #(.DIV(TICK_DIV)) u_tick (
    .clock (clock),
    .reset (reset),
    .en    (scrolling),
    .clr   (!scrolling),
    .tick  (tick)
  );

  // Clears act on the current (pre-shift) window; shifting the cleared grid
  // makes a clear on a tick erase those notes one row lower.
  always_comb begin
    clear_mask = '0;
    if (scrolling) begin
      for (int r = WIN_LO; r < ROWS; r++) begin
        clear_mask[r*LANES +: LANES] = bus.hit_clear;
      end
    end
    cleared = grid & ~clear_mask;
  end

  always_comb begin
    win_or = '0;
    for (int r = WIN_LO; r < ROWS; r++) begin
      win_or = win_or | grid[r*LANES +: LANES];
    end
  end

  always_comb begin
    state_next         = state;
    grid_next          = grid;
    addr_next          = addr;
    prefetch_next      = prefetch;
    fetch_wait_next    = fetch_wait;
    fetch_pending_next = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_next      = S_FETCH;
          addr_next       = '0;
          fetch_wait_next = 1'b0;
        end
      end
      S_FETCH: begin
        if (!fetch_wait) begin
          fetch_wait_next = 1'b1;
        end else begin
          fetch_wait_next = 1'b0;
          prefetch_next   = bus.chart_q;
          addr_next       = addr + CHART_AW'(1);
          state_next      = S_RUN;
        end
      end
      S_RUN: begin
        grid_next = cleared;
        // ROM word for the next tick is captured the cycle after a tick.
        if (fetch_pending) begin
          prefetch_next = bus.chart_q;
          addr_next     = addr + CHART_AW'(1);
        end
        if (tick) begin
          grid_next = {cleared[GW-LANES-1:0], prefetch[LANES-1:0]};
          if (prefetch[END_BIT]) begin
            state_next = S_DRAIN;
          end else begin
            fetch_pending_next = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        grid_next = cleared;
        if (tick) begin
          grid_next = {cleared[GW-LANES-1:0], {LANES{1'b0}}};
          if (grid_next == '0) begin
            state_next = S_DONE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= S_IDLE;
      grid          <= '0;
      inter         <= '0;
      gameclk       <= 1'b0;
      addr          <= '0;
      prefetch      <= '0;
      fetch_wait    <= 1'b0;
      fetch_pending <= 1'b0;
    end else begin
      state         <= state_next;
      grid          <= grid_next;
      inter         <= win_or;
      gameclk       <= tick;
      addr          <= addr_next;
      prefetch      <= prefetch_next;
      fetch_wait    <= fetch_wait_next;
      fetch_pending <= fetch_pending_next;
    end
  end

  assign bus.grid          = grid;
  assign bus.intersections = inter;
  assign bus.gameclk       = gameclk;
  assign bus.chart_addr    = addr;
  assign bus.busy          = (state == S_FETCH) || scrolling;
  assign bus.done          = (state == S_DONE);
endmodule

// File: tb/tb_note_highway.sv
// tb_note_highway
// Directed bench for note_highway. dut_a: ROWS=4, HIT_ROWS=1, TICK_DIV=4,
// chart with end marker. dut_b: ROWS=4, HIT_ROWS=2, CHART_AW=2, chart
// without end marker (loops). Outputs are sampled on the falling edge.
module tb_note_highway;
  import note_highway_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  note_highway_if #(.LANES(4), .ROWS(4), .CHART_AW(3)) bus_a ();
  note_highway_if #(.LANES(4), .ROWS(4), .CHART_AW(2)) bus_b ();

  note_highway #(.LANES(4), .ROWS(4), .HIT_ROWS(1), .TICK_DIV(4), .CHART_AW(3)) dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (bus_a)
  );

  note_highway #(.LANES(4), .ROWS(4), .HIT_ROWS(2), .TICK_DIV(4), .CHART_AW(2)) dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (bus_b)
  );

  logic [4:0] rom_a [8];
  logic [4:0] rom_b [4];

  always @(posedge clock) begin
    bus_a.chart_q <= rom_a[bus_a.chart_addr];
    bus_b.chart_q <= rom_b[bus_b.chart_addr];
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    rom_a[0] = 5'b0_0001;
    rom_a[1] = 5'b0_0000;
    rom_a[2] = 5'b0_0000;
    rom_a[3] = 5'b0_0000;
    rom_a[4] = 5'b1_0000;
    rom_a[5] = 5'b0_0000;
    rom_a[6] = 5'b0_0000;
    rom_a[7] = 5'b0_0000;
    rom_b[0] = 5'b0_0001;
    rom_b[1] = 5'b0_0010;
    rom_b[2] = 5'b0_0100;
    rom_b[3] = 5'b0_1000;

    reset = 1'b1;
    bus_a.start = 1'b0;  bus_a.hit_clear = 4'b0;
    bus_b.start = 1'b0;  bus_b.hit_clear = 4'b0;
    cyc(3);

    // Reset state
    chk("rst_state",   32'(dut_a.state), 32'(S_IDLE));
    chk("rst_grid",    32'(bus_a.grid), 32'h0);
    chk("rst_inter",   32'(bus_a.intersections), 32'h0);
    chk("rst_gameclk", 32'(bus_a.gameclk), 32'h0);
    chk("rst_addr",    32'(bus_a.chart_addr), 32'h0);
    chk("rst_busy",    32'(bus_a.busy), 32'h0);
    chk("rst_done",    32'(bus_a.done), 32'h0);

    // Song on dut_a: start sampled on the next edge (relative cycle N0)
    reset = 1'b0;
    bus_a.start = 1'b1;
    cyc(1);                                           // N1
    bus_a.start = 1'b0;
    chk("a_fetch_busy", 32'(bus_a.busy), 32'h1);
    cyc(2);                                           // N3
    chk("a_addr_run", 32'(bus_a.chart_addr), 32'h1);
    cyc(3);                                           // N6
    chk("a_gclk_pre", 32'(bus_a.gameclk), 32'h0);
    chk("a_grid_pre", 32'(bus_a.grid), 32'h0);
    cyc(1);                                           // N7
    chk("a_gclk_t1", 32'(bus_a.gameclk), 32'h1);
    chk("a_grid_t1", 32'(bus_a.grid), 32'h0001);
    cyc(1);                                           // N8
    chk("a_gclk_low", 32'(bus_a.gameclk), 32'h0);
    chk("a_addr_t1", 32'(bus_a.chart_addr), 32'h2);
    cyc(3);                                           // N11
    chk("a_gclk_t2", 32'(bus_a.gameclk), 32'h1);
    chk("a_grid_t2", 32'(bus_a.grid), 32'h0010);
    cyc(4);                                           // N15
    chk("a_grid_t3", 32'(bus_a.grid), 32'h0100);
    cyc(4);                                           // N19
    chk("a_grid_t4", 32'(bus_a.grid), 32'h1000);
    chk("a_inter_lag", 32'(bus_a.intersections), 32'h0);
    cyc(1);                                           // N20
    chk("a_inter_on", 32'(bus_a.intersections), 32'h1);
    cyc(3);                                           // N23
    chk("a_inter_last", 32'(bus_a.intersections), 32'h1);
    chk("a_grid_t5", 32'(bus_a.grid), 32'h0);
    chk("a_drain_state", 32'(dut_a.state), 32'(S_DRAIN));
    chk("a_drain_done", 32'(bus_a.done), 32'h0);
    cyc(1);                                           // N24
    chk("a_inter_off", 32'(bus_a.intersections), 32'h0);
    cyc(2);                                           // N26
    chk("a_done_early", 32'(bus_a.done), 32'h0);
    cyc(1);                                           // N27
    chk("a_done", 32'(bus_a.done), 32'h1);
    chk("a_done_busy", 32'(bus_a.busy), 32'h0);
    chk("a_done_addr", 32'(bus_a.chart_addr), 32'h5);

    // Restart with start held through DONE; second song offset by 27 cycles
    bus_a.start = 1'b1;
    cyc(1);                                           // N28
    chk("a2_busy1", 32'(bus_a.busy), 32'h1);
    cyc(1);                                           // N29
    chk("a2_busy2", 32'(bus_a.busy), 32'h1);
    chk("a2_addr0", 32'(bus_a.chart_addr), 32'h0);
    cyc(1);                                           // N30
    chk("a2_addr1", 32'(bus_a.chart_addr), 32'h1);
    cyc(5);                                           // N35
    chk("a2_addr2", 32'(bus_a.chart_addr), 32'h2);
    bus_a.start = 1'b0;
    cyc(5);                                           // N40
    bus_a.start = 1'b1;
    cyc(1);                                           // N41
    bus_a.start = 1'b0;
    chk("a2_start_ign_st", 32'(dut_a.state), 32'(S_RUN));
    chk("a2_start_ign_ad", 32'(bus_a.chart_addr), 32'h3);
    cyc(5);                                           // N46
    chk("a2_grid_bottom", 32'(bus_a.grid), 32'h1000);
    cyc(1);                                           // N47
    chk("a2_inter_on", 32'(bus_a.intersections), 32'h1);
    cyc(1);                                           // N48
    bus_a.hit_clear = 4'b0001;
    cyc(1);                                           // N49
    bus_a.hit_clear = 4'b0000;
    chk("a2_clear_grid", 32'(bus_a.grid), 32'h0);
    cyc(1);                                           // N50
    chk("a2_clear_inter", 32'(bus_a.intersections), 32'h0);
    chk("a2_exit_grid", 32'(bus_a.grid), 32'h0);
    cyc(4);                                           // N54
    chk("a2_done", 32'(bus_a.done), 32'h1);

    // Looping chart on dut_b (relative N0b = now)
    bus_b.start = 1'b1;
    cyc(1);                                           // N1b
    bus_b.start = 1'b0;
    chk("b_addr_0", 32'(bus_b.chart_addr), 32'h0);
    cyc(2);                                           // N3b
    chk("b_addr_1", 32'(bus_b.chart_addr), 32'h1);
    cyc(4);                                           // N7b
    chk("b_grid_t1", 32'(bus_b.grid), 32'h0001);
    cyc(1);                                           // N8b
    chk("b_addr_2", 32'(bus_b.chart_addr), 32'h2);
    cyc(3);                                           // N11b
    chk("b_grid_t2", 32'(bus_b.grid), 32'h0012);
    cyc(1);                                           // N12b
    chk("b_addr_3", 32'(bus_b.chart_addr), 32'h3);
    cyc(3);                                           // N15b
    chk("b_grid_t3", 32'(bus_b.grid), 32'h0124);
    cyc(1);                                           // N16b
    chk("b_addr_wrap", 32'(bus_b.chart_addr), 32'h0);
    cyc(2);                                           // N18b: tick cycle
    bus_b.hit_clear = 4'b0001;
    cyc(1);                                           // N19b
    bus_b.hit_clear = 4'b0000;
    chk("b_tick_clear", 32'(bus_b.grid), 32'h0248);
    cyc(1);                                           // N20b
    chk("b_addr_1again", 32'(bus_b.chart_addr), 32'h1);
    cyc(3);                                           // N23b
    chk("b_grid_t5", 32'(bus_b.grid), 32'h2481);
    chk("b_done_low", 32'(bus_b.done), 32'h0);
    cyc(1);                                           // N24b
    chk("b_inter", 32'(bus_b.intersections), 32'h6);
    cyc(3);                                           // N27b
    chk("b_grid_t6", 32'(bus_b.grid), 32'h4812);
    chk("b_done_low2", 32'(bus_b.done), 32'h0);

    // Reset mid-song with a non-empty grid
    reset = 1'b1;
    cyc(1);
    chk("rr_grid",    32'(bus_b.grid), 32'h0);
    chk("rr_inter",   32'(bus_b.intersections), 32'h0);
    chk("rr_addr",    32'(bus_b.chart_addr), 32'h0);
    chk("rr_busy",    32'(bus_b.busy), 32'h0);
    chk("rr_gameclk", 32'(bus_b.gameclk), 32'h0);
    chk("rr_state",   32'(dut_b.state), 32'(S_IDLE));
    chk("rr_a_done",  32'(bus_a.done), 32'h0);
    reset = 1'b0;
    cyc(2);
    chk("rr_stay_idle", 32'(bus_b.busy), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
